// File: rtl/jtag_unlock_seq.sv
// Debug-unlock sequencer in the TCK domain: pads a password, runs the HMAC handshake, holds the unlock flag and brute-force lockout.
// Optional HMAC watchdog is compiled in when JTAG_UNLOCK_TIMEOUT_EN is defined.
module jtag_unlock_seq #(
   parameter int MaxFails      = 3,
   parameter int LockoutCycles = 1024,
   parameter int TimeoutCycles = 4096
) (
   input  logic         tck_i,
   input  logic         trst_ni,
   input  logic         pw_valid_i,
   input  logic [31:0]  pw_data_i,
   output logic         pw_ready_o,
   output logic         hmac_init_o,
   output logic [511:0] hmac_msg_o,
   input  logic         hmac_ready_i,
   input  logic         hmac_valid_i,
   input  logic [255:0] hmac_hash_i,
   input  logic [255:0] exp_hash_i,
   input  logic         relock_i,
   output logic         unlock_o,
   output logic         busy_o,
   output logic         locked_out_o,
   output logic [3:0]   fail_cnt_o,
   output logic         timeout_o
);

   localparam int         LockW     = (LockoutCycles > 1) ? $clog2(LockoutCycles) : 1;
   localparam logic [3:0] MaxFailsW = 4'(MaxFails);

   if (MaxFails < 1 || MaxFails > 15 || LockoutCycles < 1 || TimeoutCycles < 1) begin : g_bad_params
      $error("jtag_unlock_seq: illegal parameter value");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_RDY,
      S_START,
      S_WAIT_HASH,
      S_COMPARE,
      S_LOCKOUT
   } state_e;

   state_e           r_state, w_state_nxt;
   logic [31:0]      r_pw, w_pw_nxt;
   logic [255:0]     r_hash, w_hash_nxt;
   logic             r_unlock, w_unlock_nxt;
   logic [3:0]       r_fail, w_fail_nxt, w_fail_inc;
   logic [LockW-1:0] r_lock_cnt, w_lock_cnt_nxt;
   logic             w_mismatch;
   logic             w_abort;

   // Saturating increment; the lockout transition normally prevents passing MaxFails.
   assign w_fail_inc = (r_fail >= MaxFailsW) ? MaxFailsW : r_fail + 4'd1;

`ifdef JTAG_UNLOCK_TIMEOUT_EN
   localparam int WdW = $clog2(TimeoutCycles + 1);

   logic [WdW-1:0] r_wdog;
   logic           r_timeout;
   logic           w_watch;

   assign w_watch = (r_state == S_START) || (r_state == S_WAIT_HASH);
   assign w_abort = w_watch && (r_wdog == WdW'(TimeoutCycles - 1));

   always_ff @(posedge tck_i or negedge trst_ni) begin
      if (!trst_ni) begin
         r_wdog    <= '0;
         r_timeout <= 1'b0;
      end else begin
         // Held at zero outside START/WAIT_HASH, so it restarts on every entry to START.
         r_wdog <= w_watch ? r_wdog + WdW'(1) : '0;
         if (w_abort) r_timeout <= 1'b1;
      end
   end

   assign timeout_o = r_timeout;
`else
   assign w_abort   = 1'b0;
   assign timeout_o = 1'b0;
`endif

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_nxt    = r_state;
      w_pw_nxt       = r_pw;
      w_hash_nxt     = r_hash;
      w_unlock_nxt   = r_unlock;
      w_fail_nxt     = r_fail;
      w_lock_cnt_nxt = r_lock_cnt;
      w_mismatch     = 1'b0;
      pw_ready_o     = 1'b0;
      hmac_init_o    = 1'b0;

      case (r_state)
         S_IDLE: begin
            pw_ready_o = 1'b1;
            if (pw_valid_i) begin
               w_pw_nxt    = pw_data_i;
               w_state_nxt = S_WAIT_RDY;
            end
         end
         S_WAIT_RDY: begin
            if (hmac_ready_i) w_state_nxt = S_START;
         end
         S_START: begin
            hmac_init_o = 1'b1;
            if (!hmac_ready_i) w_state_nxt = S_WAIT_HASH;
         end
         S_WAIT_HASH: begin
            if (hmac_valid_i) begin
               w_hash_nxt  = hmac_hash_i;
               w_state_nxt = S_COMPARE;
            end
         end
         S_COMPARE: begin
            if (r_hash == exp_hash_i) begin
               w_unlock_nxt = 1'b1;
               w_fail_nxt   = 4'd0;
               w_state_nxt  = S_IDLE;
            end else begin
               w_mismatch = 1'b1;
            end
         end
         S_LOCKOUT: begin
            if (r_lock_cnt == '0) begin
               w_fail_nxt  = 4'd0;
               w_state_nxt = S_IDLE;
            end else begin
               w_lock_cnt_nxt = r_lock_cnt - LockW'(1);
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      // A watchdog abort is charged exactly like a wrong password.
      if (w_mismatch || w_abort) begin
         w_fail_nxt = w_fail_inc;
         if (w_fail_inc == MaxFailsW) begin
            w_state_nxt    = S_LOCKOUT;
            w_lock_cnt_nxt = LockW'(LockoutCycles - 1);
         end else begin
            w_state_nxt = S_IDLE;
         end
      end

      if (relock_i) w_unlock_nxt = 1'b0;
   end

   // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge tck_i or negedge trst_ni) begin
      if (!trst_ni) begin
         r_state    <= S_IDLE;
         r_pw       <= '0;
         r_hash     <= '0;
         r_unlock   <= 1'b0;
         r_fail     <= 4'd0;
         r_lock_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_pw       <= w_pw_nxt;
         r_hash     <= w_hash_nxt;
         r_unlock   <= w_unlock_nxt;
         r_fail     <= w_fail_nxt;
         r_lock_cnt <= w_lock_cnt_nxt;
      end
   end

   assign hmac_msg_o   = {480'h0, r_pw};
   assign unlock_o     = r_unlock;
   assign fail_cnt_o   = r_fail;
   assign locked_out_o = (r_state == S_LOCKOUT);
   assign busy_o       = (r_state != S_IDLE) && (r_state != S_LOCKOUT);

endmodule

// File: tb/tb_jtag_unlock_seq.sv
// Scoreboard bench for jtag_unlock_seq: a behavioural HMAC engine, an attempt-level reference model
// and a monitor that checks each HMAC start and each completed check against queued expectations.
module tb_jtag_unlock_seq;

   localparam int          MAX_FAILS = 3;
   localparam int          LOCK_CYC  = 16;
   localparam int          TO_CYC    = 8;
   localparam logic [31:0] SECRET    = 32'hDEADBEEF;

   typedef struct {
      logic [31:0] pw;
      bit          chk_lat;
      int          acc;
   } msg_item_t;

   typedef struct {
      bit          unlock;
      logic [3:0]  fail;
      bit          lock;
      bit          to;
      bit          abort;
      logic [31:0] pw;
   } res_item_t;

   logic         tck      = 1'b0;
   logic         trst_n   = 1'b1;
   logic         pw_valid = 1'b0;
   logic [31:0]  pw_data  = '0;
   logic         r_eng_ready;
   bit           eng_block = 1'b0;
   logic         hmac_ready;
   logic         hmac_valid;
   logic [255:0] hmac_hash;
   logic [255:0] exp_hash;
   logic         relock;

   logic         pw_ready_o, hmac_init_o, unlock_o, busy_o, locked_out_o, timeout_o;
   logic [511:0] hmac_msg_o;
   logic [3:0]   fail_cnt_o;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   msg_item_t msg_q[$];
   res_item_t res_q[$];

   // Attempt-level reference model state.
   bit m_unlock = 1'b0;
   int m_fail   = 0;
   bit m_to     = 1'b0;

   bit eng_mute      = 1'b0;
   bit relock_on_cmp = 1'b0;
   int last_vdrive   = 0;

   function automatic logic [255:0] digest_of(input logic [31:0] pw);
      return {8{pw ^ 32'h5A3C_96E1}};
   endfunction

   jtag_unlock_seq #(
      .MaxFails      (MAX_FAILS),
      .LockoutCycles (LOCK_CYC),
      .TimeoutCycles (TO_CYC)
   ) dut (
      .tck_i        (tck),
      .trst_ni      (trst_n),
      .pw_valid_i   (pw_valid),
      .pw_data_i    (pw_data),
      .pw_ready_o   (pw_ready_o),
      .hmac_init_o  (hmac_init_o),
      .hmac_msg_o   (hmac_msg_o),
      .hmac_ready_i (hmac_ready),
      .hmac_valid_i (hmac_valid),
      .hmac_hash_i  (hmac_hash),
      .exp_hash_i   (exp_hash),
      .relock_i     (relock),
      .unlock_o     (unlock_o),
      .busy_o       (busy_o),
      .locked_out_o (locked_out_o),
      .fail_cnt_o   (fail_cnt_o),
      .timeout_o    (timeout_o)
   );

   always #5 tck = ~tck;
   always @(posedge tck) cyc <= cyc + 1;
   assign hmac_ready = r_eng_ready && !eng_block;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // HMAC engine model: acknowledges init by dropping ready, then returns a digest of the message.
   initial begin : engine
      r_eng_ready = 1'b1;
      hmac_valid  = 1'b0;
      hmac_hash   = '0;
      relock      = 1'b0;
      forever begin
         @(negedge tck);
         if (hmac_init_o && hmac_ready) begin
            repeat ($urandom_range(0, 2)) @(negedge tck);
            r_eng_ready = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge tck);
            if (eng_mute) begin
               while (eng_mute) @(negedge tck);
               hmac_hash = exp_hash;
            end else begin
               hmac_hash = digest_of(hmac_msg_o[31:0]);
            end
            hmac_valid  = 1'b1;
            last_vdrive = cyc;
            @(negedge tck);
            hmac_valid    = 1'b0;
            relock        = relock_on_cmp;
            relock_on_cmp = 1'b0;
            @(negedge tck);
            relock      = 1'b0;
            r_eng_ready = 1'b1;
         end
      end
   end

   initial begin : monitor
      bit        prev_busy = 1'b0;
      bit        prev_init = 1'b0;
      int        init_edge = 0;
      int        n;
      bit        bad;
      msg_item_t mi;
      res_item_t ri;
      forever begin
         @(posedge tck);
         #1;
         if (!trst_n) begin
            prev_busy = 1'b0;
            prev_init = 1'b0;
         end else begin
            if (prev_init && !hmac_init_o) check("init_held_until_ack", hmac_ready, 1'b0);
            if (hmac_init_o && !prev_init) begin
               init_edge = cyc;
               if (msg_q.size() == 0) begin
                  check("unexpected_init", hmac_init_o, 1'b0);
               end else begin
                  mi = msg_q.pop_front();
                  check("msg", hmac_msg_o, {480'h0, mi.pw});
                  if (mi.chk_lat) check("init_latency", cyc, mi.acc + 2);
               end
            end
            if (prev_busy && !busy_o) begin
               if (res_q.size() == 0) begin
                  check("unexpected_result", busy_o, 1'b1);
               end else begin
                  ri = res_q.pop_front();
                  check("unlock", unlock_o, ri.unlock);
                  check("fail_cnt", fail_cnt_o, ri.fail);
                  check("locked_out", locked_out_o, ri.lock);
                  check("timeout", timeout_o, ri.to);
                  check("msg_stable", hmac_msg_o, {480'h0, ri.pw});
                  if (ri.abort) check("abort_latency", cyc, init_edge + TO_CYC);
                  else          check("result_latency", cyc, last_vdrive + 2);
                  if (ri.lock) begin
                     n   = 0;
                     bad = 1'b0;
                     while (locked_out_o && n < LOCK_CYC + 8) begin
                        if (pw_ready_o) bad = 1'b1;
                        n++;
                        @(posedge tck);
                        #1;
                     end
                     check("lockout_len", n, LOCK_CYC);
                     check("ready_in_lockout", bad, 1'b0);
                     check("fail_after_lockout", fail_cnt_o, 4'd0);
                     check("ready_after_lockout", pw_ready_o, 1'b1);
                  end
               end
            end
            prev_busy = busy_o;
            prev_init = hmac_init_o;
         end
      end
   end

   // Issue one password; the model predicts the outcome of the whole attempt at once.
   task automatic send(input logic [31:0] pw, input bit rl, input bit junk, input bit abort);
      int        n = 0;
      bit        match;
      res_item_t ri;
      msg_item_t mi;
      @(negedge tck);
      while (!pw_ready_o && n < 400) begin
         @(negedge tck);
         n++;
      end
      if (!pw_ready_o) begin
         check("pw_ready_wait", pw_ready_o, 1'b1);
         return;
      end
      match = (pw == SECRET) && !abort;
      if (match) begin
         m_fail   = 0;
         m_unlock = !rl;
      end else begin
         m_fail = (m_fail < MAX_FAILS) ? m_fail + 1 : MAX_FAILS;
         if (rl) m_unlock = 1'b0;
      end
      if (abort) m_to = 1'b1;
      ri.unlock = m_unlock;
      ri.fail   = 4'(m_fail);
      ri.lock   = !match && (m_fail == MAX_FAILS);
      ri.to     = m_to;
      ri.abort  = abort;
      ri.pw     = pw;
      if (ri.lock) m_fail = 0;
      mi.pw      = pw;
      mi.chk_lat = !eng_block;
      mi.acc     = cyc;
      msg_q.push_back(mi);
      res_q.push_back(ri);
      relock_on_cmp = rl;
      pw_valid      = 1'b1;
      pw_data       = pw;
      @(negedge tck);
      pw_valid = 1'b0;
      if (junk) begin
         pw_data  = $urandom;
         pw_valid = 1'b1;
         @(negedge tck);
         pw_valid = 1'b0;
      end
   endtask

   task automatic wait_done();
      int n = 0;
      while ((res_q.size() != 0 || !pw_ready_o) && n < 600) begin
         @(negedge tck);
         n++;
      end
      if (res_q.size() != 0 || !pw_ready_o) check("drain_wait", res_q.size(), 0);
   endtask

   initial begin : stimulus
      logic [31:0] pw;
      int          bad_init, bad_busy, n;
      exp_hash = digest_of(SECRET);

      #3 trst_n = 1'b0;
      repeat (2) @(posedge tck);
      #1;
      check("rst_pw_ready", pw_ready_o, 1'b1);
      check("rst_init", hmac_init_o, 1'b0);
      check("rst_busy", busy_o, 1'b0);
      check("rst_unlock", unlock_o, 1'b0);
      check("rst_fail", fail_cnt_o, 4'd0);
      check("rst_locked", locked_out_o, 1'b0);
      check("rst_timeout", timeout_o, 1'b0);
      check("rst_msg", hmac_msg_o, 512'h0);
      @(negedge tck);
      trst_n = 1'b1;

      // Correct password, then a standalone relock while unlocked.
      send(SECRET, 1'b0, 1'b0, 1'b0);
      wait_done();
      check("unlocked_before_relock", unlock_o, m_unlock);
      @(negedge tck);
      relock = 1'b1;
      @(posedge tck);
      #1;
      check("relock_clear", unlock_o, 1'b0);
      m_unlock = 1'b0;
      @(negedge tck);
      relock = 1'b0;

      // Three wrong passwords into lockout.
      for (int i = 0; i < MAX_FAILS; i++) send(SECRET ^ (32'h1 << i), 1'b0, 1'b1, 1'b0);
      wait_done();

      // Engine busy: ready held low after accept.
      eng_block = 1'b1;
      send(SECRET, 1'b0, 1'b0, 1'b0);
      bad_init = 0;
      bad_busy = 0;
      repeat (20) begin
         @(posedge tck);
         #1;
         if (hmac_init_o) bad_init++;
         if (!busy_o)     bad_busy++;
      end
      check("init_while_engine_busy", bad_init, 0);
      check("busy_while_waiting", bad_busy, 0);
      @(negedge tck);
      eng_block = 1'b0;
      @(posedge tck);
      #1;
      check("init_after_ready", hmac_init_o, 1'b1);
      wait_done();

      // Relock coinciding with a matching compare.
      @(negedge tck);
      relock = 1'b1;
      @(negedge tck);
      relock   = 1'b0;
      m_unlock = 1'b0;
      send(SECRET, 1'b1, 1'b0, 1'b0);
      wait_done();

      for (int i = 0; i < 30; i++) begin
         pw = ($urandom_range(0, 2) == 0) ? SECRET : $urandom;
         send(pw, ($urandom_range(0, 5) == 0), $urandom_range(0, 1) == 1, 1'b0);
      end
      wait_done();

      // Reset in WAIT_HASH with two failures recorded; a late digest must be ignored.
      send(SECRET, 1'b0, 1'b0, 1'b0);
      send(SECRET ^ 32'h10, 1'b0, 1'b0, 1'b0);
      send(SECRET ^ 32'h20, 1'b0, 1'b0, 1'b0);
      wait_done();
      check("pre_reset_fail", fail_cnt_o, 4'(m_fail));
      eng_mute = 1'b1;
      send(SECRET ^ 32'h40, 1'b0, 1'b0, 1'b0);
      n = 0;
      while (hmac_ready && n < 50) begin
         @(negedge tck);
         n++;
      end
      check("engine_ack_wait", hmac_ready, 1'b0);
      repeat (2) @(negedge tck);
      #2 trst_n = 1'b0;
      #1;
      check("arst_busy", busy_o, 1'b0);
      check("arst_pw_ready", pw_ready_o, 1'b1);
      check("arst_init", hmac_init_o, 1'b0);
      check("arst_unlock", unlock_o, 1'b0);
      check("arst_fail", fail_cnt_o, 4'd0);
      check("arst_locked", locked_out_o, 1'b0);
      check("arst_timeout", timeout_o, 1'b0);
      check("arst_msg", hmac_msg_o, 512'h0);
      res_q.delete();
      msg_q.delete();
      m_fail   = 0;
      m_unlock = 1'b0;
      m_to     = 1'b0;
      repeat (2) @(negedge tck);
      trst_n = 1'b1;
      @(negedge tck);
      eng_mute = 1'b0;
      repeat (6) @(negedge tck);
      check("stray_valid_unlock", unlock_o, 1'b0);
      check("stray_valid_busy", busy_o, 1'b0);
      check("stray_valid_fail", fail_cnt_o, 4'd0);

`ifdef JTAG_UNLOCK_TIMEOUT_EN
      // Engine never answers: watchdog abort counts as a failure; the late digest is dropped.
      wait_done();
      eng_mute = 1'b1;
      send(SECRET, 1'b0, 1'b0, 1'b1);
      wait_done();
      eng_mute = 1'b0;
      repeat (6) @(negedge tck);
      check("late_valid_unlock", unlock_o, m_unlock);
      check("late_valid_busy", busy_o, 1'b0);
      check("timeout_sticky", timeout_o, 1'b1);
`endif

      wait_done();
      check("queues_empty", msg_q.size() + res_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : global_guard
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
      $fatal(1, "global timeout");
   end

endmodule

// File: doc/jtag_unlock_seq.md
Name: jtag_unlock_seq

Overview:
- Sequencer in the JTAG TCK domain that owns the HMAC engine for debug-unlock password checks.
- Accepts a 32-bit password word from the DMI front-end and pads it to a 512-bit message.
- Runs the HMAC init/ready/valid handshake, compares the digest against the expected hash, and holds the sticky unlock flag.
- Enforces a failed-attempt counter with a timed lockout so the password cannot be brute-forced at TCK rate.

Parameters:
- MaxFails, 3: consecutive failed checks that trigger lockout; legal range 1..15.
- LockoutCycles, 1024: TCK cycles spent in lockout; must be ≥1.
- TimeoutCycles, 4096: HMAC watchdog limit; used only with the optional feature.

Ports:
- tck_i  in  1  JTAG test clock; all state is in this domain.
- trst_ni  in  1  Reset, asynchronous, active-low.
- pw_valid_i  in  1  Password word valid.
- pw_data_i  in  32  Password word.
- pw_ready_o  out  1  Sequencer can accept a password.
- hmac_init_o  out  1  HMAC start request.
- hmac_msg_o  out  512  HMAC message, {480'h0, password}.
- hmac_ready_i  in  1  HMAC idle/ready.
- hmac_valid_i  in  1  HMAC digest valid.
- hmac_hash_i  in  256  HMAC digest.
- exp_hash_i  in  256  Expected digest; quasi-static.
- relock_i  in  1  Clear unlock.
- unlock_o  out  1  Debug unlocked, sticky.
- busy_o  out  1  Check in progress, i.e. state not IDLE and not LOCKOUT.
- locked_out_o  out  1  In lockout.
- fail_cnt_o  out  4  Consecutive failures.
- timeout_o  out  1  Sticky watchdog error.

Behaviour:
- Reset values: all outputs 0 except pw_ready_o=1; state IDLE; message register 0; counters 0.
- FSM states:
  - IDLE: pw_ready_o=1. Handshake completes when pw_valid_i&pw_ready_o; pw_data_i is latched into msg[31:0], msg[511:32]=0, next state WAIT_RDY. pw_valid_i while not ready is ignored; there is no queueing.
  - WAIT_RDY: stay until hmac_ready_i=1, then go to START.
  - START: hmac_init_o=1. Stay until hmac_ready_i=0, then go to WAIT_HASH. hmac_init_o is therefore a level held until the engine acknowledges by dropping ready.
  - WAIT_HASH: on hmac_valid_i, register hmac_hash_i and go to COMPARE.
  - COMPARE (1 cycle), full 256-bit equality:
    - Match: unlock_o←1, fail_cnt←0, next state IDLE.
    - Mismatch: fail_cnt←fail_cnt+1. If the new value equals MaxFails, go to LOCKOUT and load the lockout counter with LockoutCycles-1; otherwise go to IDLE.
  - LOCKOUT: locked_out_o=1, pw_ready_o=0. Decrement each cycle; at 0, fail_cnt←0 and go to IDLE.
- Latency: accept at cycle N with hmac_ready_i=1 → hmac_init_o=1 from N+2. Digest valid at cycle M → unlock_o or fail_cnt update visible from M+2.
- hmac_msg_o is stable from WAIT_RDY through COMPARE and is not modified in IDLE until the next accept.
- relock_i clears unlock_o in any state. If relock_i coincides with a COMPARE match, relock_i wins and unlock_o stays 0; fail_cnt is still cleared.
- A successful check while already unlocked leaves unlock_o=1.
- fail_cnt saturates at MaxFails; it never wraps.
- hmac_valid_i outside WAIT_HASH is ignored.
- trst_ni asserted mid-check returns the FSM to IDLE immediately, clears unlock_o, fail_cnt and lockout, and drops hmac_init_o asynchronously.

Optional Feature:
- Macro: JTAG_UNLOCK_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles spent in START+WAIT_HASH and clears on entry to START.
  - Reaching TimeoutCycles aborts the check and sets timeout_o sticky; only trst_ni clears it.
  - The abort is treated as a mismatch, including the fail_cnt increment and possible LOCKOUT.
  - A late hmac_valid_i after the abort is ignored.
- Not defined: no watchdog logic; timeout_o is tied 0; START and WAIT_HASH wait indefinitely.

Test Plan:
- Correct password: exp_hash_i = digest D; send pw 0xDEADBEEF with a model returning D → unlock_o=1 two cycles after hmac_valid_i, fail_cnt_o=0, hmac_msg_o[31:0]=0xDEADBEEF, upper bits 0.
- Three wrong passwords with MaxFails=3, LockoutCycles=16 → fail_cnt_o steps 1, 2, 3; locked_out_o=1 for 16 cycles with pw_ready_o=0; then fail_cnt_o=0 and pw_ready_o=1.
- Engine busy: hold hmac_ready_i=0 for 20 cycles after accept → hmac_init_o stays 0, busy_o=1. Raise ready → init=1 next cycle, held until ready drops.
- relock_i pulsed in the same cycle as a COMPARE match → unlock_o stays 0. A later relock_i pulse while unlocked → unlock_o=0 the following cycle.
- trst_ni asserted in WAIT_HASH with fail_cnt=2 → all outputs return to reset values asynchronously; a subsequent hmac_valid_i has no effect.
- With JTAG_UNLOCK_TIMEOUT_EN and TimeoutCycles=8: never assert hmac_valid_i → timeout_o=1 and fail_cnt_o=1 after 8 cycles in START+WAIT_HASH, FSM back in IDLE.
